// File: rtl/snake_key_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, counter debounce and a 5-state FSM that
// produces a debounced level plus press/release/long-press pulses. Auto-repeat: SNAKE_KEY_AUTOREPEAT_EN.
module snake_key_conditioner #(
    parameter int CNT_W             = 16,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 20,
    parameter int REPEAT_CYCLES     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        LONG_HELD,
        RELEASE_DEB
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // With a single-sample debounce the entry sample already completes the debounce.
    localparam bit DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

    logic s1;
    logic key_s;

    state_t           state, state_n;
    logic [CNT_W-1:0] deb_cnt, deb_n;
    logic [CNT_W-1:0] long_cnt, long_n;
    logic             was_long, was_long_n;
    logic             press_n, release_n, long_pulse_n, level_n;

`ifdef SNAKE_KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt, rep_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            key_s <= 1'b0;
        end else begin
            s1    <= key_raw;
            key_s <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            was_long    <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_n;
            deb_cnt     <= deb_n;
            long_cnt    <= long_n;
            was_long    <= was_long_n;
            key_level   <= level_n;
            key_press   <= press_n;
            key_release <= release_n;
            key_long    <= long_pulse_n;
        end
    end

`ifdef SNAKE_KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_n;
        end
    end
`endif

    always_comb begin
        state_n      = state;
        deb_n        = deb_cnt;
        long_n       = long_cnt;
        was_long_n   = was_long;
        press_n      = 1'b0;
        release_n    = 1'b0;
        long_pulse_n = 1'b0;
`ifdef SNAKE_KEY_AUTOREPEAT_EN
        rep_n        = rep_cnt;
`endif

        case (state)
            IDLE: begin
                if (key_s) begin
                    if (DEB_SINGLE) begin
                        state_n = HELD;
                        press_n = 1'b1;
                        long_n  = '0;
                        deb_n   = '0;
                    end else begin
                        state_n = PRESS_DEB;
                        deb_n   = CNT_ONE;
                    end
                end
            end

            PRESS_DEB: begin
                if (!key_s) begin
                    state_n = IDLE;
                    deb_n   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_n = HELD;
                    press_n = 1'b1;
                    long_n  = '0;
                    deb_n   = '0;
                end else begin
                    deb_n = deb_cnt + CNT_ONE;
                end
            end

            HELD: begin
                // A low sample wins over long-press expiry; long_cnt stays frozen meanwhile.
                if (!key_s) begin
                    if (DEB_SINGLE) begin
                        state_n    = IDLE;
                        release_n  = 1'b1;
                        was_long_n = 1'b0;
                        deb_n      = '0;
                    end else begin
                        state_n = RELEASE_DEB;
                        deb_n   = CNT_ONE;
                    end
                end else if (long_cnt >= LONG_LAST) begin
                    state_n      = LONG_HELD;
                    long_pulse_n = 1'b1;
                    long_n       = LONG_TERM;
                    was_long_n   = 1'b1;
`ifdef SNAKE_KEY_AUTOREPEAT_EN
                    rep_n        = '0;
`endif
                end else begin
                    long_n = long_cnt + CNT_ONE;
                end
            end

            LONG_HELD: begin
                if (!key_s) begin
                    if (DEB_SINGLE) begin
                        state_n    = IDLE;
                        release_n  = 1'b1;
                        was_long_n = 1'b0;
                        deb_n      = '0;
                    end else begin
                        state_n = RELEASE_DEB;
                        deb_n   = CNT_ONE;
                    end
                end
`ifdef SNAKE_KEY_AUTOREPEAT_EN
                else if (rep_cnt >= REP_LAST) begin
                    press_n = 1'b1;
                    rep_n   = '0;
                end else begin
                    rep_n = rep_cnt + CNT_ONE;
                end
`endif
            end

            RELEASE_DEB: begin
                if (key_s) begin
                    state_n = was_long ? LONG_HELD : HELD;
                    deb_n   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_n    = IDLE;
                    release_n  = 1'b1;
                    was_long_n = 1'b0;
                    deb_n      = '0;
                end else begin
                    deb_n = deb_cnt + CNT_ONE;
                end
            end

            default: begin
                state_n = IDLE;
                deb_n   = '0;
            end
        endcase

        level_n = (state_n == HELD) || (state_n == LONG_HELD) || (state_n == RELEASE_DEB);
    end

endmodule

// File: tb/tb_snake_key_conditioner.sv
// Scoreboard bench for snake_key_conditioner: stimulus queues expected pulses with
// hand-computed cycle numbers; a negedge monitor pops and compares each observed pulse.
module tb_snake_key_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic key_raw;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int at;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    snake_key_conditioner #(
        .CNT_W            (16),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .REPEAT_CYCLES    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    // cyc is the index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input int kind);
        exp_q.push_back('{at: at, kind: kind});
    endtask

    task automatic pop_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual_kind=%0d required=none (cyc=%0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (key_press)   pop_ev(K_PRESS);
            if (key_release) pop_ev(K_RELEASE);
            if (key_long)    pop_ev(K_LONG);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_press(output int n);
        @(negedge clk);
        key_raw = 1'b1;
        n = cyc + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int m;

        rst     = 1'b1;
        key_raw = 1'b0;

        // 1: reset held while key_raw toggles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key_raw = ~key_raw;
            #1;
            check("reset_outputs", int'({key_level, key_press, key_release, key_long}), 0);
        end
        @(negedge clk);
        key_raw = 1'b0;
        rst     = 1'b0;
        repeat (4) @(negedge clk);

        // 2: 12-cycle press
        start_press(n);
        expect_ev(n + 5, K_PRESS);
        expect_ev(n + 17, K_RELEASE);
        wait_cyc(n + 4);
        check("t2_level_before", int'(key_level), 0);
        wait_cyc(n + 5);
        check("t2_level_rise", int'(key_level), 1);
        wait_cyc(n + 11);
        key_raw = 1'b0;
        wait_cyc(n + 16);
        check("t2_level_hold", int'(key_level), 1);
        wait_cyc(n + 17);
        check("t2_level_fall", int'(key_level), 0);
        wait_cyc(n + 30);
        check("t2_queue_drained", exp_q.size(), 0);

        // 3: 3-cycle bounce, rejected
        start_press(n);
        wait_cyc(n + 2);
        key_raw = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            wait_cyc(n + i);
            check("t3_level_low", int'(key_level), 0);
        end
        wait_cyc(n + 20);
        check("t3_queue_drained", exp_q.size(), 0);

        // 4: 60-cycle hold, long press and optional auto-repeat
        start_press(n);
        expect_ev(n + 5, K_PRESS);
        expect_ev(n + 25, K_LONG);
`ifdef SNAKE_KEY_AUTOREPEAT_EN
        expect_ev(n + 33, K_PRESS);
        expect_ev(n + 41, K_PRESS);
        expect_ev(n + 49, K_PRESS);
        expect_ev(n + 57, K_PRESS);
`endif
        expect_ev(n + 65, K_RELEASE);
        wait_cyc(n + 40);
        check("t4_level_long", int'(key_level), 1);
        wait_cyc(n + 59);
        key_raw = 1'b0;
        wait_cyc(n + 80);
        check("t4_queue_drained", exp_q.size(), 0);
        check("t4_level_idle", int'(key_level), 0);

        // 5: two-cycle release glitch while HELD
        start_press(n);
        expect_ev(n + 5, K_PRESS);
        expect_ev(n + 21, K_RELEASE);
        wait_cyc(n + 7);
        key_raw = 1'b0;
        wait_cyc(n + 9);
        key_raw = 1'b1;
        wait_cyc(n + 11);
        check("t5_level_glitch", int'(key_level), 1);
        wait_cyc(n + 13);
        check("t5_level_after", int'(key_level), 1);
        wait_cyc(n + 15);
        key_raw = 1'b0;
        wait_cyc(n + 35);
        check("t5_queue_drained", exp_q.size(), 0);

        // 6: reset while LONG_HELD with the key still down
        start_press(n);
        expect_ev(n + 5, K_PRESS);
        expect_ev(n + 25, K_LONG);
        wait_cyc(n + 28);
        check("t6_level_long", int'(key_level), 1);
        rst = 1'b1;
        #1;
        check("t6_async_clear", int'({key_level, key_press, key_release, key_long}), 0);
        check("t6_queue_before_rst", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n2 = cyc + 1;
        expect_ev(n2 + 5, K_PRESS);
        wait_cyc(n2 + 4);
        check("t6_level_redebounce", int'(key_level), 0);
        wait_cyc(n2 + 10);
        key_raw = 1'b0;
        m = n2 + 11;
        expect_ev(m + 5, K_RELEASE);
        wait_cyc(m + 15);
        check("t6_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
